// File: rtl/placement_result_collector_if.sv
// rtl/placement_result_collector_if.sv - Result stream between the collector and its consumer.
// The master drives the show-ahead head entry; the slave accepts it with ready.
interface placement_result_collector_if;
    logic       valid;
    logic       ready;
    logic [7:0] x;
    logic [7:0] y;
    logic [3:0] strike;
    logic       struck;

    modport master (output valid, x, y, strike, struck, input ready);
    modport slave  (input valid, x, y, strike, struck, output ready);
endinterface

// File: rtl/placement_result_collector.sv
// rtl/placement_result_collector.sv - Realigns placer outputs with their requests and queues them.
// A valid delay line marks when the fixed-latency placer result is present; results go into a show-ahead FIFO.
module placement_result_collector #(
    parameter int LATENCY = 8,
    parameter int DEPTH   = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_valid_i,
    input  logic [7:0]                index_x_i,
    input  logic [7:0]                index_y_i,
    input  logic [3:0]                strike_i,
    placement_result_collector_if.master res,
    output logic [$clog2(DEPTH):0]    level_o,
    output logic [15:0]               placed_cnt_o,
    output logic                      overflow_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [3:0] strike;
        logic       struck;
    } result_t;

    logic [LATENCY-1:0] vp_q, vp_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]      level_q, level_d;
    logic [15:0]        placed_q, placed_d;
    logic               overflow_q, overflow_d;
    logic [3:0]         last_strike_q, last_strike_d;
    result_t            mem_q [DEPTH];
    result_t            cap_res;
    result_t            head;
    logic               capture, full, head_valid, pop, push;

    always_comb begin
        vp_d          = vp_q << 1;
        vp_d[0]       = req_valid_i;
        capture       = vp_q[LATENCY-1];
        full          = (level_q == LW'(DEPTH));
        head_valid    = (level_q != '0);
        pop           = head_valid && res.ready;
        push          = capture && (!full || pop);
        cap_res       = '{x: index_x_i, y: index_y_i, strike: strike_i,
                          struck: (strike_i != last_strike_q)};

        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        level_d       = level_q;
        placed_d      = placed_q;
        overflow_d    = overflow_q;
        last_strike_d = last_strike_q;

        // The strike reference advances on every capture, dropped or not.
        if (capture) begin
            last_strike_d = strike_i;
        end
        if (capture && !push) begin
            overflow_d = 1'b1;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (placed_q != 16'hFFFF) begin
                placed_d = placed_q + 16'd1;
            end
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vp_q          <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            placed_q      <= '0;
            overflow_q    <= 1'b0;
            last_strike_q <= '0;
        end else begin
            vp_q          <= vp_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            placed_q      <= placed_d;
            overflow_q    <= overflow_d;
            last_strike_q <= last_strike_d;
        end
    end

    // Storage is left alone by reset; an empty FIFO never exposes it.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cap_res;
        end
    end

    always_comb begin
        head       = mem_q[rd_ptr_q];
        res.valid  = head_valid;
        res.x      = head_valid ? head.x      : '0;
        res.y      = head_valid ? head.y      : '0;
        res.strike = head_valid ? head.strike : '0;
        res.struck = head_valid ? head.struck : 1'b0;
    end

    assign level_o      = level_q;
    assign placed_cnt_o = placed_q;
    assign overflow_o   = overflow_q;
endmodule

// File: tb/tb_placement_result_collector.sv
// tb/tb_placement_result_collector.sv - Scoreboard bench for placement_result_collector.
// A placer stand-in schedules index/strike data LATENCY edges after each request.
`timescale 1ns/1ps
module tb_placement_result_collector;
    localparam int LAT   = 8;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [3:0] strike;
        logic       struck;
    } res_t;

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic [3:0] strike;
        logic       exp_struck;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0;
    logic [7:0]    ix = '0;
    logic [7:0]    iy = '0;
    logic [3:0]    istk = '0;
    logic [LW-1:0] level;
    logic [15:0]   placed;
    logic          overflow;

    placement_result_collector_if res_if();

    placement_result_collector #(.LATENCY(LAT), .DEPTH(DEPTH)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .index_x_i    (ix),
        .index_y_i    (iy),
        .strike_i     (istk),
        .res          (res_if),
        .level_o      (level),
        .placed_cnt_o (placed),
        .overflow_o   (overflow)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [19:0] plan [int];
    logic [19:0] next_data = '0;
    res_t        exp_q [$];
    logic [3:0]  m_last = '0;
    int          m_placed = 0;
    logic        m_ovf = 1'b0;
    int          m_drops = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] dut_vec();
        return 64'({res_if.valid, res_if.x, res_if.y, res_if.strike, res_if.struck,
                    level, placed, overflow});
    endfunction

    function automatic logic [63:0] model_vec();
        res_t          h;
        logic          ev;
        logic [LW-1:0] el;
        ev = (exp_q.size() != 0);
        h  = ev ? exp_q[0] : '0;
        el = LW'(exp_q.size());
        return 64'({ev, h, el, 16'(m_placed), m_ovf});
    endfunction

    // One clock: check against the model, drive placer data, advance the model across the edge.
    task automatic step();
        logic [19:0] d;
        logic        cap, pop, full;
        res_t        r;
        @(negedge clk);
        check("cycle", dut_vec(), model_vec());
        cap = plan.exists(cyc + 1);
        if (cap) begin
            d = plan[cyc + 1];
            plan.delete(cyc + 1);
        end else begin
            d = 20'($urandom);
        end
        {ix, iy, istk} = d;
        if (req_valid) plan[cyc + 1 + LAT] = next_data;
        pop  = (exp_q.size() != 0) && res_if.ready;
        full = (exp_q.size() == DEPTH);
        if (pop) void'(exp_q.pop_front());
        if (cap) begin
            r.x      = d[19:12];
            r.y      = d[11:4];
            r.strike = d[3:0];
            r.struck = (d[3:0] != m_last);
            m_last   = d[3:0];
            if (!full || pop) begin
                exp_q.push_back(r);
                if (m_placed < 65535) m_placed++;
            end else begin
                m_ovf = 1'b1;
                m_drops++;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        plan.delete();
        exp_q.delete();
        m_last   = '0;
        m_placed = 0;
        m_ovf    = 1'b0;
        m_drops  = 0;
        check("reset_outputs", dut_vec(), 64'd0);
        @(posedge clk);
        cyc++;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [6];
        int   issued;
        tbl[0] = '{8'h12, 8'h34, 4'h0, 1'b0};
        tbl[1] = '{8'h56, 8'h78, 4'h1, 1'b1};
        tbl[2] = '{8'h9A, 8'hBC, 4'h1, 1'b0};
        tbl[3] = '{8'hDE, 8'hF0, 4'hF, 1'b1};
        tbl[4] = '{8'h11, 8'h22, 4'h0, 1'b1};
        tbl[5] = '{8'h33, 8'h44, 4'h0, 1'b0};
        res_if.ready = 1'b0;
        #1;
        do_reset();

        // Isolated requests: result appears one cycle after capture, stays one cycle under ready.
        res_if.ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            next_data = {tbl[i].x, tbl[i].y, tbl[i].strike};
            req_valid = 1'b1;
            step();
            req_valid = 1'b0;
            repeat (LAT - 1) step();
            check("pre_capture_valid", 64'(res_if.valid), 64'd0);
            step();
            check("single_valid", 64'(res_if.valid), 64'd1);
            check("single_data", 64'({res_if.x, res_if.y, res_if.strike, res_if.struck}),
                  64'({tbl[i].x, tbl[i].y, tbl[i].strike, tbl[i].exp_struck}));
            step();
            check("single_one_cycle", 64'(res_if.valid), 64'd0);
            check("single_placed", 64'(placed), 64'(i + 1));
        end

        // Backpressure: nine back-to-back requests into an eight-entry FIFO.
        do_reset();
        res_if.ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            next_data = {8'(8'h80 + i), 8'(8'h40 + i), 4'(i)};
            req_valid = 1'b1;
            step();
        end
        req_valid = 1'b0;
        repeat (LAT - 1) step();
        check("bp_level_full", 64'(level), 64'(DEPTH));
        check("bp_no_overflow", 64'(overflow), 64'd0);
        step();
        check("bp_overflow", 64'(overflow), 64'd1);
        check("bp_level_kept", 64'(level), 64'(DEPTH));
        check("bp_placed", 64'(placed), 64'd8);
        res_if.ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("bp_drain_x", 64'(res_if.x), 64'(8'h80 + i));
            step();
        end
        check("bp_drained", 64'(level), 64'd0);

        // Full FIFO with a pop on the same edge as a capture.
        do_reset();
        res_if.ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            next_data = {8'(8'hA0 + i), 8'(8'h20 + i), 4'(i)};
            req_valid = 1'b1;
            step();
        end
        req_valid = 1'b0;
        repeat (LAT - 1) step();
        check("fp_level_full", 64'(level), 64'(DEPTH));
        res_if.ready = 1'b1;
        step();
        res_if.ready = 1'b0;
        check("fp_level_kept", 64'(level), 64'(DEPTH));
        check("fp_no_overflow", 64'(overflow), 64'd0);
        check("fp_head_x", 64'(res_if.x), 64'h A1);
        check("fp_placed", 64'(placed), 64'd9);
        res_if.ready = 1'b1;
        repeat (DEPTH + 2) step();
        check("fp_drained", 64'(level), 64'd0);

        // Reset three edges after a request, with an older result still held.
        do_reset();
        res_if.ready = 1'b0;
        next_data = {8'h55, 8'h66, 4'h3};
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        repeat (LAT) step();
        next_data = {8'h77, 8'h88, 4'h5};
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        repeat (3) step();
        do_reset();
        repeat (LAT + 2) step();
        check("rst_no_capture", dut_vec(), 64'd0);

        // Random stream with random backpressure.
        do_reset();
        issued = 0;
        while (issued < 1000) begin
            req_valid    = ($urandom_range(0, 9) < 7);
            res_if.ready = 1'($urandom_range(0, 1));
            if (req_valid) begin
                next_data = 20'($urandom);
                issued++;
            end
            step();
        end
        req_valid    = 1'b0;
        res_if.ready = 1'b0;
        repeat (LAT + 1) step();
        check("rand_accounted", 64'(placed) + 64'(m_drops), 64'd1000);
        res_if.ready = 1'b1;
        repeat (DEPTH + 2) step();
        check("rand_drained", 64'(level), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
